// File: rtl/frame_seq.sv
// Frame sequencer: gates a filter stage between a source FIFO and a sink FIFO
// for exactly one frame per start request, with drain watchdog and overrun flag.
module frame_seq #(
  parameter int IMG_WIDTH    = 720,
  parameter int IMG_HEIGHT   = 540,
  parameter int IN_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
  parameter int OUT_PIXELS   = IMG_WIDTH * IMG_HEIGHT,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        overrun,
  output logic        timeout,
  output logic        stage_reset,
  input  logic        src_empty,
  output logic        src_rd_en,
  input  logic        stage_rd_en,
  output logic        stage_empty,
  input  logic        snk_full,
  output logic        snk_wr_en,
  input  logic        stage_wr_en,
  output logic        stage_full,
  input  logic        stage_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int CL_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IN_LIM   = CNT_W'(IN_PIXELS);
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_PIXELS - 1);
  localparam logic [CNT_W-1:0] OUT_LIM  = CNT_W'(OUT_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [CL_W-1:0]  CL_LAST  = CL_W'(CLEAR_CYCLES - 1);
  localparam logic [CL_W-1:0]  CL_ONE   = CL_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] in_cnt_r, out_cnt_r;
  logic [WD_W-1:0]  wdog_r;
  logic [CL_W-1:0]  clr_cnt_r;
  logic [15:0]      frame_count_r;
  logic             busy_r, frame_done_r, overrun_r, timeout_r, stage_reset_r;
  logic             stage_empty_s, stage_full_s, src_rd_en_s, snk_wr_en_s, wd_expire_s;

  // Next-state and zero-latency FIFO gating; stage sees empty/full outside RUN/DRAIN.
  always_comb begin
    state_s       = state_r;
    stage_empty_s = 1'b1;
    stage_full_s  = 1'b1;
    src_rd_en_s   = 1'b0;
    snk_wr_en_s   = 1'b0;
    wd_expire_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      CLEAR: begin
        if (clr_cnt_r == CL_LAST) state_s = RUN;
        else                      state_s = CLEAR;
      end
      RUN: begin
        stage_empty_s = src_empty | (in_cnt_r == IN_LIM);
        src_rd_en_s   = stage_rd_en & ~stage_empty_s;
        stage_full_s  = snk_full;
        snk_wr_en_s   = stage_wr_en & ~snk_full;
        if (src_rd_en_s && (in_cnt_r == IN_LAST)) state_s = DRAIN;
        else                                      state_s = RUN;
      end
      DRAIN: begin
        stage_full_s = snk_full;
        snk_wr_en_s  = stage_wr_en & ~snk_full;
        wd_expire_s  = ~snk_wr_en_s & (wdog_r == WD_LAST);
        // A completion report with too few writes is ignored; the watchdog still runs.
        if (stage_done && (out_cnt_r >= OUT_LIM)) state_s = DONE;
        else if (wd_expire_s)                     state_s = DONE;
        else                                      state_s = DRAIN;
      end
      DONE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      in_cnt_r      <= '0;
      out_cnt_r     <= '0;
      wdog_r        <= '0;
      clr_cnt_r     <= '0;
      frame_count_r <= 16'd0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      overrun_r     <= 1'b0;
      timeout_r     <= 1'b0;
      stage_reset_r <= 1'b1;
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s != IDLE);
      frame_done_r  <= (state_s == DONE);
      stage_reset_r <= (state_s == CLEAR);

      if (state_s == DONE) frame_count_r <= frame_count_r + 16'd1;

      if (state_r == CLEAR) clr_cnt_r <= clr_cnt_r + CL_ONE;
      else                  clr_cnt_r <= '0;

      if (state_r == CLEAR)  in_cnt_r <= '0;
      else if (src_rd_en_s)  in_cnt_r <= in_cnt_r + CNT_ONE;

      // out_cnt saturates at OUT_PIXELS; extra writes still reach the sink.
      if (state_r == CLEAR)                          out_cnt_r <= '0;
      else if (snk_wr_en_s && (out_cnt_r != OUT_LIM)) out_cnt_r <= out_cnt_r + CNT_ONE;

      if (state_r == DRAIN) begin
        if (snk_wr_en_s) wdog_r <= '0;
        else             wdog_r <= wdog_r + WD_ONE;
      end else begin
        wdog_r <= '0;
      end

      if (state_s == CLEAR)                            overrun_r <= 1'b0;
      else if (snk_wr_en_s && (out_cnt_r == OUT_LIM))  overrun_r <= 1'b1;

      if (state_s == CLEAR)  timeout_r <= 1'b0;
      else if (wd_expire_s)  timeout_r <= 1'b1;
    end
  end

  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign frame_count = frame_count_r;
  assign overrun     = overrun_r;
  assign timeout     = timeout_r;
  assign stage_reset = stage_reset_r;
  assign stage_empty = stage_empty_s;
  assign stage_full  = stage_full_s;
  assign src_rd_en   = src_rd_en_s;
  assign snk_wr_en   = snk_wr_en_s;

endmodule
